// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // One register-file write port beat.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_port_t;

    // One buffered load result waiting for the write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lsu_entry_t;

    localparam int LSU_ENTRY_W = REG_ADDR_W + XLEN;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small circular buffer holding load results until the write port is free.
// Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH naturally.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Storage has no reset: stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: merges fixed-latency ALU results with
// buffered load results onto one registered write port, and keeps a
// pending-load scoreboard for the decode stage.
//
// Handshake: an LSU result transfers on a rising edge where lsu_vld=1 and
// lsu_rdy=1; lsu_vld must not depend on lsu_rdy. The ALU has no ready and is
// instead throttled by alu_hold (upstream keeps alu_vld=0 while it is 1).
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int LSU_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_vld,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_vld,
    output logic                  lsu_rdy,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  iss_vld,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  alu_hold,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  waw_err
);

    localparam int CNT_W = $clog2(LSU_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSU_DEPTH);

    wb_port_t              r_wb;
    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_waw_err;

    wb_port_t              w_wb_next;
    logic [NUM_REGS-1:0]   w_busy_set;
    logic [NUM_REGS-1:0]   w_busy_clr;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic [CNT_W-1:0]      w_count;
    logic [LSU_ENTRY_W-1:0] w_head_bits;
    lsu_entry_t            w_head;
    lsu_entry_t            w_push_entry;
    logic                  w_lsu_rdy;
    logic                  w_alu_hold;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_waw_hit;

    // Flow control comes only from the registered occupancy.
    assign w_lsu_rdy  = (w_count < FULL_CNT);
    assign w_alu_hold = (w_count == FULL_CNT);

    // Loads always enter the buffer; the ALU owns the port whenever it is valid.
    assign w_push       = lsu_vld && w_lsu_rdy;
    assign w_pop        = !alu_vld && (w_count != '0);
    assign w_push_entry = '{rd: lsu_rd, data: lsu_data};
    assign w_head       = lsu_entry_t'(w_head_bits);

    wb_fifo #(
        .DEPTH (LSU_DEPTH),
        .WIDTH (LSU_ENTRY_W)
    ) u_wb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_entry),
        .o_rdata (w_head_bits),
        .o_count (w_count)
    );

    // Select the next write-port beat; rd=0 results are consumed without a write.
    always_comb begin
        w_wb_next    = r_wb;
        w_wb_next.we = 1'b0;
        if (alu_vld) begin
            w_wb_next.we   = (alu_rd != '0);
            w_wb_next.addr = alu_rd;
            w_wb_next.data = alu_data;
        end else if (w_pop) begin
            w_wb_next.we   = (w_head.rd != '0);
            w_wb_next.addr = w_head.rd;
            w_wb_next.data = w_head.data;
        end
    end

    // Scoreboard update: issue sets, load retirement clears, set wins on overlap.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (iss_vld && (iss_rd != '0)) begin
            w_busy_set[iss_rd] = 1'b1;
        end
        if (w_pop && (w_head.rd != '0)) begin
            w_busy_clr[w_head.rd] = 1'b1;
        end
        w_busy_next = (r_busy & ~w_busy_clr) | w_busy_set;
    end

    // An ALU write over a pending load, or an ALU write ignoring alu_hold, is a protocol error.
    assign w_waw_hit = alu_vld && (((alu_rd != '0) && r_busy[alu_rd]) || w_alu_hold);

    // Registered write port, scoreboard and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb      <= '0;
            r_busy    <= '0;
            r_waw_err <= 1'b0;
        end else begin
            r_wb      <= w_wb_next;
            r_busy    <= w_busy_next;
            r_waw_err <= r_waw_err | w_waw_hit;
        end
    end

    assign lsu_rdy  = w_lsu_rdy;
    assign alu_hold = w_alu_hold;
    assign busy1    = r_busy[chk_rs1] & (chk_rs1 != '0);
    assign busy2    = r_busy[chk_rs2] & (chk_rs2 != '0);
    assign rf_we    = r_wb.we;
    assign rf_waddr = r_wb.addr;
    assign rf_wdata = r_wb.data;
    assign waw_err  = r_waw_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a table of single-cycle vectors followed
// by hand-written sequences for reset and ALU-over-hold ordering.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_vld;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_vld;
    logic        lsu_rdy;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_vld;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        busy1;
    logic        busy2;
    logic        alu_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        waw_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [36:0] exp_q[$];

    rf_wb_arbiter #(.LSU_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_vld  (alu_vld),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .lsu_vld  (lsu_vld),
        .lsu_rdy  (lsu_rdy),
        .lsu_rd   (lsu_rd),
        .lsu_data (lsu_data),
        .iss_vld  (iss_vld),
        .iss_rd   (iss_rd),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .busy1    (busy1),
        .busy2    (busy2),
        .alu_hold (alu_hold),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .waw_err  (waw_err)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_b1;
        logic        e_b2;
        logic        e_rdy;
        logic        e_hold;
        logic        e_waw;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_vld  = 1'b0;
        alu_rd   = '0;
        alu_data = '0;
        lsu_vld  = 1'b0;
        lsu_rd   = '0;
        lsu_data = '0;
        iss_vld  = 1'b0;
        iss_rd   = '0;
    endtask

    // Step, then check any write against the expected-write queue.
    task automatic step_sb();
        logic [36:0] exp_w;
        step();
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("sb_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, exp_w});
            end
        end
    endtask

    initial begin
        //            av ard   adata          lv lrd   ldata          iv ird   c1    c2     we addr  data           b1 b2 rdy hold waw
        vecs[0]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[1]  = '{1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  1, 5'd5, 32'h1234_5678, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd7, 5'd7, 5'd0,  0, 5'd0, 32'h0,         1, 0, 1, 0, 0};
        vecs[3]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  0, 5'd0, 32'h0,         1, 0, 1, 0, 0};
        vecs[4]  = '{0, 5'd0, 32'h0,         1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0, 5'd7, 5'd0,  0, 5'd0, 32'h0,         1, 0, 1, 0, 0};
        vecs[5]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  1, 5'd7, 32'hDEAD_BEEF, 0, 0, 1, 0, 0};
        vecs[6]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[7]  = '{1, 5'd1, 32'h11,        1, 5'd3, 32'h33,        0, 5'd0, 5'd3, 5'd4,  1, 5'd1, 32'h11,        0, 0, 1, 0, 0};
        vecs[8]  = '{1, 5'd2, 32'h22,        1, 5'd4, 32'h44,        0, 5'd0, 5'd3, 5'd4,  1, 5'd2, 32'h22,        0, 0, 0, 1, 0};
        vecs[9]  = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd3, 5'd4,  1, 5'd3, 32'h33,        0, 0, 1, 0, 0};
        vecs[10] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd3, 5'd4,  1, 5'd4, 32'h44,        0, 0, 1, 0, 0};
        vecs[11] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[12] = '{1, 5'd0, 32'hAA,        0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[13] = '{0, 5'd0, 32'h0,         1, 5'd0, 32'hBB,        0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[14] = '{0, 5'd0, 32'h0,         1, 5'd0, 32'hCC,        0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[15] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 0};
        vecs[16] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd9, 5'd9, 5'd9,  0, 5'd0, 32'h0,         1, 1, 1, 0, 0};
        vecs[17] = '{1, 5'd9, 32'h99,        0, 5'd0, 32'h0,         0, 5'd0, 5'd9, 5'd9,  1, 5'd9, 32'h99,        1, 1, 1, 0, 1};
        vecs[18] = '{0, 5'd0, 32'h0,         1, 5'd9, 32'h9A,        0, 5'd0, 5'd9, 5'd0,  0, 5'd0, 32'h0,         1, 0, 1, 0, 1};
        vecs[19] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd9, 5'd0,  1, 5'd9, 32'h9A,        0, 0, 1, 0, 1};
        vecs[20] = '{0, 5'd0, 32'h0,         1, 5'd9, 32'h9B,        0, 5'd0, 5'd9, 5'd0,  0, 5'd0, 32'h0,         0, 0, 1, 0, 1};
        vecs[21] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd9, 5'd9, 5'd0,  1, 5'd9, 32'h9B,        1, 0, 1, 0, 1};
        vecs[22] = '{0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 5'd9, 5'd7,  0, 5'd0, 32'h0,         1, 0, 1, 0, 1};

        // Reset state, checked while rst_n is low.
        drive_idle();
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd0;
        rst_n   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rf_we",    rf_we,    0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_lsu_rdy",  lsu_rdy,  1);
        check("rst_alu_hold", alu_hold, 0);
        check("rst_busy1",    busy1,    0);
        check("rst_busy2",    busy2,    0);
        check("rst_waw_err",  waw_err,  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven vectors: inputs held across one edge, outputs checked after it.
        for (int i = 0; i < NVEC; i++) begin
            alu_vld  = vecs[i].av;
            alu_rd   = vecs[i].ard;
            alu_data = vecs[i].adata;
            lsu_vld  = vecs[i].lv;
            lsu_rd   = vecs[i].lrd;
            lsu_data = vecs[i].ldata;
            iss_vld  = vecs[i].iv;
            iss_rd   = vecs[i].ird;
            chk_rs1  = vecs[i].c1;
            chk_rs2  = vecs[i].c2;
            step();
            check($sformatf("v%0d_rf_we", i), rf_we, vecs[i].e_we);
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_rf_waddr", i), rf_waddr, vecs[i].e_addr);
                check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_data);
            end
            check($sformatf("v%0d_busy1", i),    busy1,    vecs[i].e_b1);
            check($sformatf("v%0d_busy2", i),    busy2,    vecs[i].e_b2);
            check($sformatf("v%0d_lsu_rdy", i),  lsu_rdy,  vecs[i].e_rdy);
            check($sformatf("v%0d_alu_hold", i), alu_hold, vecs[i].e_hold);
            check($sformatf("v%0d_waw_err", i),  waw_err,  vecs[i].e_waw);
        end

        // Fill the buffer to two entries with a pending load, then reset mid-cycle.
        drive_idle();
        alu_vld = 1'b1; alu_rd = 5'd13; alu_data = 32'h13;
        lsu_vld = 1'b1; lsu_rd = 5'd14; lsu_data = 32'h14;
        iss_vld = 1'b1; iss_rd = 5'd13;
        chk_rs1 = 5'd13; chk_rs2 = 5'd0;
        step();
        alu_rd = 5'd15; alu_data = 32'h15;
        lsu_rd = 5'd16; lsu_data = 32'h16;
        iss_vld = 1'b0;
        step();
        check("fill_alu_hold", alu_hold, 1);
        check("fill_busy1",    busy1,    1);
        check("fill_rf_we",    rf_we,    1);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rf_we",    rf_we,    0);
        check("midrst_rf_waddr", rf_waddr, 0);
        check("midrst_rf_wdata", rf_wdata, 0);
        check("midrst_lsu_rdy",  lsu_rdy,  1);
        check("midrst_alu_hold", alu_hold, 0);
        check("midrst_busy1",    busy1,    0);
        check("midrst_waw_err",  waw_err,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("postrst_idle%0d_rf_we", k), rf_we, 0);
        end

        // ALU writes while alu_hold=1: flagged, written, and the pops wait behind it.
        alu_vld = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0;
        lsu_vld = 1'b1; lsu_rd = 5'd21; lsu_data = 32'hB1;
        exp_q.push_back({5'd20, 32'hA0});
        step_sb();
        alu_rd = 5'd22; alu_data = 32'hA2;
        lsu_rd = 5'd23; lsu_data = 32'hB3;
        exp_q.push_back({5'd22, 32'hA2});
        step_sb();
        check("hold_alu_hold", alu_hold, 1);
        check("hold_lsu_rdy",  lsu_rdy,  0);
        check("hold_waw_err",  waw_err,  0);
        alu_rd = 5'd24; alu_data = 32'hA4;
        lsu_rd = 5'd25; lsu_data = 32'hB5;
        exp_q.push_back({5'd24, 32'hA4});
        step_sb();
        check("ovr_waw_err",  waw_err,  1);
        check("ovr_alu_hold", alu_hold, 1);
        drive_idle();
        exp_q.push_back({5'd21, 32'hB1});
        exp_q.push_back({5'd23, 32'hB3});
        for (int k = 0; k < 3; k++) begin
            step_sb();
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_rf_we",       rf_we,        0);
        check("drain_lsu_rdy",     lsu_rdy,      1);
        check("drain_waw_sticky",  waw_err,      1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
